// File: rtl/cover_pkg.sv
// Shared types for the toggle-coverage collector: global index type and
// output-slot state encoding.
package cover_pkg;

  localparam int COVER_IDX_W = 64;

  typedef logic [COVER_IDX_W-1:0] cover_idx_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/cover_prio_enc.sv
// Lowest-set-bit priority encoder used to pick the next pending cover point.
module cover_prio_enc #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vector,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    found = |vector;
    index = '0;
    // Scan downward so the last match written is the lowest set bit.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vector[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/toggle_cover_collector.sv
// Sticky toggle-coverage collector: latches first hits per point and streams
// each newly covered point once, lowest index first, over a valid/ready port.
module toggle_cover_collector
  import cover_pkg::*;
#(
  parameter int         WIDTH       = 62,
  parameter cover_idx_t COVER_INDEX = '0,
  parameter int         CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] valid,
  input  logic             enable,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output cover_idx_t       out_index,
  output logic [WIDTH-1:0] covered,
  output logic [CNT_W-1:0] covered_count,
  output logic             all_covered
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  slot_state_t      r_state;
  slot_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_covered;
  logic [WIDTH-1:0] r_pending;
  logic [CNT_W-1:0] r_count;
  cover_idx_t       r_out_index;

  logic             w_clr;
  logic [WIDTH-1:0] w_new;
  logic [WIDTH-1:0] w_take;
  logic [CNT_W-1:0] w_new_cnt;
  logic             w_load;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  // Pairwise reduction gives a log-depth adder tree rather than a long chain.
  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] s [WIDTH];
    for (int i = 0; i < WIDTH; i++) s[i] = CNT_W'(v[i]);
    for (int step = 1; step < WIDTH; step = step * 2) begin
      for (int i = 0; i + step < WIDTH; i = i + 2 * step) begin
        s[i] = s[i] + s[i + step];
      end
    end
    return s[0];
  endfunction

  cover_prio_enc #(.WIDTH(WIDTH)) u_prio (
    .vector (r_pending),
    .found  (w_found),
    .index  (w_idx)
  );

  always_comb begin
    w_clr       = reset | clear;
    w_new       = (enable && !w_clr) ? (valid & ~r_covered) : '0;
    w_new_cnt   = popcount(w_new);
    w_load      = (r_state == SLOT_EMPTY) || out_ready;
    w_take      = '0;
    w_state_nxt = r_state;
    if (w_load) begin
      if (w_found) begin
        w_state_nxt = SLOT_FULL;
        w_take      = WIDTH'(1) << w_idx;
      end else begin
        w_state_nxt = SLOT_EMPTY;
      end
    end
    // An in-flight index is dropped on clear even if the handshake fires.
    if (w_clr) w_state_nxt = SLOT_EMPTY;
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= SLOT_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_covered   <= '0;
      r_pending   <= '0;
      r_count     <= '0;
      r_out_index <= '0;
    end else begin
      r_covered <= r_covered | w_new;
      r_pending <= (r_pending & ~w_take) | w_new;
      r_count   <= r_count + w_new_cnt;
      if (w_load && w_found) r_out_index <= COVER_INDEX + cover_idx_t'(w_idx);
    end
  end

  assign out_valid     = (r_state == SLOT_FULL);
  assign out_index     = r_out_index;
  assign covered       = r_covered;
  assign covered_count = r_count;
  assign all_covered   = (r_count == CNT_W'(WIDTH));

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Directed bench for toggle_cover_collector with WIDTH=62, COVER_INDEX=100.
module tb_toggle_cover_collector;

  localparam int          WIDTH = 62;
  localparam int          CNT_W = $clog2(WIDTH + 1);
  localparam logic [63:0] BASE  = 64'd100;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] valid;
  logic             enable;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_index;
  logic [WIDTH-1:0] covered;
  logic [CNT_W-1:0] covered_count;
  logic             all_covered;

  int checks = 0;
  int errors = 0;

  toggle_cover_collector #(
    .WIDTH       (WIDTH),
    .COVER_INDEX (BASE),
    .CNT_W       (CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .valid         (valid),
    .enable        (enable),
    .clear         (clear),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_index     (out_index),
    .covered       (covered),
    .covered_count (covered_count),
    .all_covered   (all_covered)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid = '0; enable = 1'b1; clear = 1'b0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_index !== 64'd0 || covered !== '0 ||
          covered_count !== '0 || all_covered !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got ov=%b idx=%0d cov=%h cnt=%0d all=%b, want all zero",
                 i, out_valid, out_index, covered, covered_count, all_covered);
      end
    end
  endtask

  task automatic test_two_hits();
    out_ready = 1'b1;
    valid = (WIDTH'(1) << 5) | (WIDTH'(1) << 3);
    tick();
    valid = '0;
    checks++;
    if (covered_count !== CNT_W'(2) || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL two_hits_count: got cnt=%0d ov=%b, want cnt=2 ov=0", covered_count, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_index !== 64'd103) begin
      errors++;
      $display("FAIL two_hits_first: got ov=%b idx=%0d, want ov=1 idx=103", out_valid, out_index);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_index !== 64'd105) begin
      errors++;
      $display("FAIL two_hits_second: got ov=%b idx=%0d, want ov=1 idx=105", out_valid, out_index);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL two_hits_drain: got ov=%b, want 0", out_valid);
    end
  endtask

  task automatic test_repeat();
    valid = (WIDTH'(1) << 5) | (WIDTH'(1) << 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || covered_count !== CNT_W'(2)) begin
        errors++;
        $display("FAIL repeat_hit cycle %0d: got ov=%b cnt=%0d, want ov=0 cnt=2", i, out_valid, covered_count);
      end
    end
    valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    // Hit in descending order within one cycle; stream must still ascend.
    valid = (WIDTH'(1) << 30) | (WIDTH'(1) << 20) | (WIDTH'(1) << 10);
    tick();
    valid = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_index !== 64'd110) begin
        errors++;
        $display("FAIL backpressure_hold cycle %0d: got ov=%b idx=%0d, want ov=1 idx=110", i, out_valid, out_index);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_index !== 64'd120) begin
      errors++;
      $display("FAIL backpressure_rel1: got ov=%b idx=%0d, want ov=1 idx=120", out_valid, out_index);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_index !== 64'd130) begin
      errors++;
      $display("FAIL backpressure_rel2: got ov=%b idx=%0d, want ov=1 idx=130", out_valid, out_index);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || covered_count !== CNT_W'(5)) begin
      errors++;
      $display("FAIL backpressure_done: got ov=%b cnt=%0d, want ov=0 cnt=5", out_valid, covered_count);
    end
  endtask

  task automatic test_all_ones();
    do_clear();
    out_ready = 1'b1;
    valid = '1;
    tick();
    valid = '0;
    checks++;
    if (covered_count !== CNT_W'(62) || all_covered !== 1'b1 || covered !== {WIDTH{1'b1}}) begin
      errors++;
      $display("FAIL all_ones_count: got cnt=%0d all=%b, want cnt=62 all=1", covered_count, all_covered);
    end
    for (int k = 0; k < WIDTH; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_index !== BASE + 64'(k)) begin
        errors++;
        $display("FAIL all_ones_stream beat %0d: got ov=%b idx=%0d, want ov=1 idx=%0d",
                 k, out_valid, out_index, BASE + 64'(k));
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL all_ones_end: got ov=%b, want 0", out_valid);
    end
  endtask

  task automatic test_clear_handshake();
    do_clear();
    out_ready = 1'b1;
    valid = (WIDTH'(1) << 1) | (WIDTH'(1) << 2);
    tick();
    valid = '0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_index !== 64'd101) begin
      errors++;
      $display("FAIL clear_setup: got ov=%b idx=%0d, want ov=1 idx=101", out_valid, out_index);
    end
    clear = 1'b1;
    valid = WIDTH'(1) << 7;
    tick();
    clear = 1'b0;
    valid = '0;
    checks++;
    if (out_valid !== 1'b0 || covered_count !== '0 || covered !== '0) begin
      errors++;
      $display("FAIL clear_wipe: got ov=%b cnt=%0d cov=%h, want all zero", out_valid, covered_count, covered);
    end
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_dropped: got ov=%b idx=%0d, want ov=0", out_valid, out_index);
    end
    valid = WIDTH'(1) << 7;
    tick();
    valid = '0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_index !== 64'd107 || covered_count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL clear_rehit: got ov=%b idx=%0d cnt=%0d, want ov=1 idx=107 cnt=1",
               out_valid, out_index, covered_count);
    end
    tick();
  endtask

  task automatic test_enable_off();
    enable = 1'b0;
    valid = '1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || covered !== (WIDTH'(1) << 7) || covered_count !== CNT_W'(1) ||
          all_covered !== 1'b0) begin
        errors++;
        $display("FAIL enable_off cycle %0d: got ov=%b cov=%h cnt=%0d, want ov=0 cov=bit7 cnt=1",
                 i, out_valid, covered, covered_count);
      end
    end
    valid = '0;
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_two_hits();
    test_repeat();
    test_backpressure();
    test_all_ones();
    test_clear_handshake();
    test_enable_off();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/toggle_cover_collector.md
# toggle_cover_collector

Hardware-side consumer of per-point toggle-coverage strobes, one instance per producer group. It samples a WIDTH-bit hit vector every cycle and keeps a sticky covered bitmap and a covered-point count. Each first hit of a point is queued and streamed out once as a global cover index over a valid/ready port, lowest index first. This lets FPGA/emulation builds and formal harnesses read toggle coverage without DPI.

## Interface
- WIDTH, 62: number of cover points in this group; legal range 1..1024.
- COVER_INDEX, 0: global index of bit 0; point i reports COVER_INDEX + i.
- CNT_W, $clog2(WIDTH+1): width of covered_count.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- valid  in  WIDTH  per-point hit strobes; bit i high means point i toggled this cycle.
- enable  in  1  sample valid only when high.
- clear  in  1  synchronous wipe of all coverage state.
- out_valid  out  1  out_index holds an unreported first hit.
- out_ready  in  1  consumer accepts out_index when out_valid && out_ready.
- out_index  out  64  global cover index, unsigned.
- covered  out  WIDTH  sticky bitmap of points hit since reset or clear.
- covered_count  out  CNT_W  population count of covered.
- all_covered  out  1  covered is all ones.

## Operation
- new = valid & ~covered when enable && !clear; otherwise 0.
- Every edge: covered |= new; pending |= new; covered_count += popcount(new). Count add is exact and never saturates, because count ≤ WIDTH by construction.
- Output slot is a single register with two states:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1; out_index stable.
- Slot loads when EMPTY, or when FULL and the handshake fires this cycle.
  - Load source: lowest set bit p of pending at that edge.
  - On load: out_index <= COVER_INDEX + p; bit p cleared from pending; state <= FULL.
  - If pending is empty at a load opportunity: state <= EMPTY.
- Back-to-back: with out_ready held high and pending non-empty, one index transfers per cycle.
- Each point is reported exactly once per reset/clear epoch. A repeated hit on a covered point has no effect.
- New pending bits set at edge E are eligible for load from edge E+1.
- Points are selected in strict lowest-index order among pending bits at each load, not in hit order.
- out_index arithmetic is 64-bit unsigned: COVER_INDEX zero-extended, plus p.
- all_covered = (covered_count == WIDTH).
- clear (and reset) at an edge: covered, pending and covered_count go to 0, and the slot goes to EMPTY.
  - This applies even if a transfer handshake is active that cycle; the in-flight index is dropped.
  - valid in that cycle is ignored.
- clear and reset have identical effect; reset has precedence only nominally.

## Timing
- Reset values: out_valid 0, out_index 0, covered 0, covered_count 0, all_covered 0.
- Hit sampled at edge E0: covered and covered_count updated after E0. out_valid rises after E1 when the slot is empty and the point is the lowest pending.
- Handshake at edge E (out_valid && out_ready): the next index, if any, appears after E with no bubble.
- out_valid, once high, stays high and out_index stays stable until the handshake completes or clear/reset. Backpressure of any length is legal.
- out_ready may depend combinationally on out_valid. out_valid never depends on out_ready in the same cycle.
- All outputs are registered; there is no combinational input-to-output path.
- enable low: valid is ignored. Pending draining continues.

## Structure
- Shared package cover_pkg:
  - COVER_IDX_W = 64.
  - typedef cover_idx_t (logic [63:0]).
  - typedef enum slot_state_t {SLOT_EMPTY, SLOT_FULL}.
- Sub-module cover_prio_enc, parameterised on WIDTH:
  - Input: vector.
  - Outputs: found, lowest set index ($clog2(WIDTH) bits).
  - Pure combinational.
- Popcount of new computed in-module as an adder tree. No other sub-modules.

## Test plan
- Reset then idle: all outputs 0 for 10 cycles; all_covered 0.
- COVER_INDEX=100, WIDTH=62, single-cycle valid=bit5|bit3, out_ready=1:
  - covered_count reads 2 one cycle later.
  - Output stream is 103 then 105 on consecutive cycles, then out_valid 0.
- Same hit repeated on 5 later cycles: no further out_valid, count stays 2.
- Backpressure: out_ready=0 for 20 cycles with 3 pending; out_index is held at the lowest value throughout; release yields 3 transfers in 3 cycles.
- valid all ones in one cycle:
  - count becomes 62 and all_covered 1 after one edge.
  - Stream is COVER_INDEX+0..+61 in order, 62 beats.
- clear asserted during an active handshake with valid=bit7 in the same cycle:
  - Next cycle: out_valid 0, count 0, covered 0.
  - A later hit on bit7 reports COVER_INDEX+7 again.
- enable=0 with valid=all ones: no state change.
